mult_div_unit: RTL and testbench

//  Iterative multiply/divide unit with the architectural HI/LO registers for MULT, MULTU, DIV, DIVU,

---
 rtl/mips_pkg.sv | 18 +
 rtl/md_shift_core.sv | 32 +++
 rtl/mult_div_unit.sv | 136 +++++++++++++
 tb/tb_mult_div_unit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states and default width.
package mips_pkg;

    localparam int MD_WIDTH = 32;

    localparam logic [1:0] MD_MULTU = 2'b00;
    localparam logic [1:0] MD_MULT  = 2'b01;
    localparam logic [1:0] MD_DIVU  = 2'b10;
    localparam logic [1:0] MD_DIV   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } md_state_t;

endpackage

// File: rtl/md_shift_core.sv
// One iteration of the shared 2*WIDTH accumulator: shift-add for multiply,
// restoring shift-subtract for divide. Purely combinational.
module md_shift_core #(
    parameter int WIDTH = 32
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted_rem;
    logic [WIDTH:0] diff;

    // Multiply keeps {partial product, remaining multiplier bits}; divide keeps {remainder, dividend/quotient}.
    // The partial remainder is always below the divisor, so the top bit of diff is a clean borrow flag.
    always_comb begin
        sum         = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        shifted_rem = acc[2*WIDTH-1:WIDTH-1];
        diff        = shifted_rem - {1'b0, operand};
        acc_next    = {sum, acc[WIDTH-1:1]};
        if (is_div) begin
            if (!diff[WIDTH]) begin
                acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {acc[2*WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// Operands are reduced to magnitudes on entry and the signs are restored in FIX.
module mult_div_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic             hilo_sel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hilo_out
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] ITERATIONS = CW'(WIDTH);

    md_state_t          state;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   operand;
    logic [WIDTH-1:0]   a_raw;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;
    logic               is_div;
    logic               neg_res;
    logic               neg_rem;
    logic               div_zero;
    logic               op_signed;
    logic               op_div;

    assign op_signed = (op == MD_MULT) || (op == MD_DIV);
    assign op_div    = (op == MD_DIVU) || (op == MD_DIV);
    assign a_mag     = (op_signed && a[WIDTH-1]) ? -a : a;
    assign b_mag     = (op_signed && b[WIDTH-1]) ? -b : b;
    assign hilo_out  = hilo_sel ? hi : lo;

    md_shift_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .is_div  (is_div),
        .acc     (acc),
        .operand (operand),
        .acc_next(acc_next)
    );

    // Divide by zero bypasses sign correction so DIV and DIVU both return the raw unsigned pattern.
    always_comb begin
        prod   = neg_res ? -acc : acc;
        quot   = acc[WIDTH-1:0];
        rem    = acc[2*WIDTH-1:WIDTH];
        fix_hi = prod[2*WIDTH-1:WIDTH];
        fix_lo = prod[WIDTH-1:0];
        if (div_zero) begin
            fix_hi = a_raw;
            fix_lo = '1;
        end else if (is_div) begin
            fix_hi = neg_rem ? -rem : rem;
            fix_lo = neg_res ? -quot : quot;
        end
    end

    // DONE accepts a new start just like IDLE, which gives back-to-back issue with no bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= '0;
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            acc      <= '0;
            operand  <= '0;
            a_raw    <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (start) begin
                        state    <= RUN;
                        busy     <= 1'b1;
                        count    <= '0;
                        is_div   <= op_div;
                        neg_res  <= op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_rem  <= op_signed && a[WIDTH-1];
                        div_zero <= op_div && (b == '0);
                        a_raw    <= a;
                        acc      <= {{WIDTH{1'b0}}, (op_div ? a_mag : b_mag)};
                        operand  <= op_div ? b_mag : a_mag;
                    end else begin
                        if (mthi) hi <= a;
                        if (mtlo) lo <= a;
                    end
                end
                RUN: begin
                    if (count == ITERATIONS) begin
                        state <= FIX;
                    end else begin
                        acc   <= acc_next;
                        count <= count + 1'b1;
                    end
                end
                FIX: begin
                    hi    <= fix_hi;
                    lo    <= fix_lo;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    count <= '0;
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random ops
// compared against a plain-arithmetic model of MULT/MULTU/DIV/DIVU.
module tb_mult_div_unit;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi;
    logic        mtlo;
    logic        hilo_sel;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] hilo_out;

    int total = 0;
    int bad   = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .mthi    (mthi),
        .mtlo    (mtlo),
        .hilo_sel(hilo_sel),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo),
        .hilo_out(hilo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result as {HI, LO}, straight from the architectural definition.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx;
        longint      sy;
        longint      q;
        longint      r;
        logic [63:0] m;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        m  = 64'h0;
        case (o)
            OP_MULTU: m = {32'h0, x} * {32'h0, y};
            OP_MULT:  m = 64'(sx * sy);
            default: begin
                if (y == 32'h0) begin
                    m = {x, 32'hFFFF_FFFF};
                end else if (o == OP_DIVU) begin
                    m = {x % y, x / y};
                end else begin
                    q = sx / sy;
                    r = sx % sy;
                    m = {r[31:0], q[31:0]};
                end
            end
        endcase
        return m;
    endfunction

    task automatic wait_done(output int done_at, output int busy_cnt);
        done_at  = 0;
        busy_cnt = 0;
        for (int c = 1; c <= 60 && done_at == 0; c++) begin
            if (busy) busy_cnt++;
            if (done) done_at = c;
            else @(negedge clk);
        end
    endtask

    task automatic run_op(input bit now, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int done_at, output int busy_cnt);
        if (!now) @(negedge clk);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op    = 2'($urandom);
        a     = $urandom;
        b     = $urandom;
        wait_done(done_at, busy_cnt);
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        start    = 1'b0;
        mthi     = 1'b0;
        mtlo     = 1'b0;
        hilo_sel = 1'b0;
        op       = 2'b00;
        a        = $urandom;
        b        = $urandom;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        total++; if (hi !== 32'h0) begin bad++; $display("[TB] FAIL reset_hi: got %h expected 0", hi); end
        total++; if (lo !== 32'h0) begin bad++; $display("[TB] FAIL reset_lo: got %h expected 0", lo); end
        rst_n = 1'b1;
    endtask

    task automatic test_multiply();
        int d;
        int bc;
        run_op(1'b0, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, d, bc);
        total++; if (d != 35) begin bad++; $display("[TB] FAIL multu_latency: got %0d expected 35", d); end
        total++; if (hi !== 32'hFFFF_FFFE) begin bad++; $display("[TB] FAIL multu_hi: got %h expected fffffffe", hi); end
        total++; if (lo !== 32'h0000_0001) begin bad++; $display("[TB] FAIL multu_lo: got %h expected 00000001", lo); end
        run_op(1'b0, OP_MULT, 32'hFFFF_FFFD, 32'd7, d, bc);
        total++; if (bc != 34) begin bad++; $display("[TB] FAIL mult_busy_cycles: got %0d expected 34", bc); end
        total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("[TB] FAIL mult_hi: got %h expected ffffffff", hi); end
        total++; if (lo !== 32'hFFFF_FFEB) begin bad++; $display("[TB] FAIL mult_lo: got %h expected ffffffeb", lo); end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL done_one_cycle: got %b expected 0", done); end
    endtask

    task automatic test_divide();
        int d;
        int bc;
        run_op(1'b0, OP_DIV, 32'hFFFF_FFF9, 32'd2, d, bc);
        total++; if (lo !== 32'hFFFF_FFFD) begin bad++; $display("[TB] FAIL div_lo: got %h expected fffffffd", lo); end
        total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("[TB] FAIL div_hi: got %h expected ffffffff", hi); end
        run_op(1'b0, OP_DIVU, 32'd100, 32'd7, d, bc);
        total++; if (lo !== 32'd14) begin bad++; $display("[TB] FAIL divu_lo: got %h expected 0000000e", lo); end
        total++; if (hi !== 32'd2) begin bad++; $display("[TB] FAIL divu_hi: got %h expected 00000002", hi); end
        run_op(1'b0, OP_DIVU, 32'd100, 32'd0, d, bc);
        total++; if (d != 35) begin bad++; $display("[TB] FAIL divzero_latency: got %0d expected 35", d); end
        total++; if (lo !== 32'hFFFF_FFFF) begin bad++; $display("[TB] FAIL divzero_lo: got %h expected ffffffff", lo); end
        total++; if (hi !== 32'h0000_0064) begin bad++; $display("[TB] FAIL divzero_hi: got %h expected 00000064", hi); end
        run_op(1'b0, OP_DIV, 32'hFFFF_FF00, 32'd0, d, bc);
        total++; if (lo !== 32'hFFFF_FFFF) begin bad++; $display("[TB] FAIL sdivzero_lo: got %h expected ffffffff", lo); end
        total++; if (hi !== 32'hFFFF_FF00) begin bad++; $display("[TB] FAIL sdivzero_hi: got %h expected ffffff00", hi); end
        run_op(1'b0, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, d, bc);
        total++; if (lo !== 32'h8000_0000) begin bad++; $display("[TB] FAIL div_overflow_lo: got %h expected 80000000", lo); end
        total++; if (hi !== 32'h0) begin bad++; $display("[TB] FAIL div_overflow_hi: got %h expected 00000000", hi); end
    endtask

    task automatic test_random();
        int          d;
        int          bc;
        logic [1:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        logic [63:0] exp;
        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            case ($urandom_range(0, 5))
                0:       y = 32'h0;
                1:       y = 32'($urandom_range(1, 15));
                2:       y = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                default: y = $urandom;
            endcase
            exp = model(o, x, y);
            run_op(1'b0, o, x, y, d, bc);
            total++; if (d != 35 || bc != 34) begin bad++; $display("[TB] FAIL rand_timing[%0d]: got done=%0d busy=%0d expected 35/34", i, d, bc); end
            total++; if ({hi, lo} !== exp) begin bad++; $display("[TB] FAIL rand_result[%0d] op=%0d a=%h b=%h: got %h_%h expected %h_%h", i, o, x, y, hi, lo, exp[63:32], exp[31:0]); end
        end
    endtask

    task automatic test_moves();
        int d;
        int bc;
        @(negedge clk);
        a = 32'h0000_1234; mthi = 1'b1;
        @(negedge clk);
        mthi = 1'b0;
        total++; if (hi !== 32'h0000_1234) begin bad++; $display("[TB] FAIL mthi: got %h expected 00001234", hi); end
        hilo_sel = 1'b1; #1;
        total++; if (hilo_out !== 32'h0000_1234) begin bad++; $display("[TB] FAIL hilo_out_hi: got %h expected 00001234", hilo_out); end
        a = 32'h0000_ABCD; mthi = 1'b1; mtlo = 1'b1;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        total++; if (hi !== 32'h0000_ABCD || lo !== 32'h0000_ABCD) begin bad++; $display("[TB] FAIL mthi_mtlo: got %h/%h expected 0000abcd/0000abcd", hi, lo); end
        a = 32'h0000_1111; mthi = 1'b1;
        @(negedge clk);
        mthi = 1'b0; hilo_sel = 1'b0; #1;
        total++; if (hilo_out !== 32'h0000_ABCD || hi !== 32'h0000_1111) begin bad++; $display("[TB] FAIL mthi_only: got lo=%h hi=%h expected 0000abcd/00001111", hilo_out, hi); end

        // Moves and a second start while busy must be ignored.
        op = OP_DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
        d = 0;
        for (int c = 1; c <= 60 && d == 0; c++) begin
            if (c == 5) begin start = 1'b1; mtlo = 1'b1; mthi = 1'b1; op = OP_MULTU; a = 32'hDEAD_0000; end
            if (c == 6) begin start = 1'b0; mtlo = 1'b0; mthi = 1'b0; end
            if (c == 12) begin
                total++; if (lo !== 32'h0000_ABCD || hi !== 32'h0000_1111) begin bad++; $display("[TB] FAIL busy_moves_ignored: got %h/%h expected 00001111/0000abcd", hi, lo); end
            end
            if (done) d = c;
            else @(negedge clk);
        end
        total++; if (d != 35 || lo !== 32'd14 || hi !== 32'd2) begin bad++; $display("[TB] FAIL busy_start_ignored: got done=%0d hi=%h lo=%h expected 35/2/e", d, hi, lo); end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL no_extra_op: got busy=%b expected 0", busy); end

        // start wins over simultaneous moves in IDLE.
        op = OP_MULTU; a = 32'h0000_5555; b = 32'd3; start = 1'b1; mthi = 1'b1; mtlo = 1'b1;
        @(negedge clk);
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        total++; if (hi !== 32'd2 || lo !== 32'd14 || busy !== 1'b1) begin bad++; $display("[TB] FAIL start_beats_moves: got hi=%h lo=%h busy=%b expected 2/e/1", hi, lo, busy); end
        wait_done(d, bc);
        total++; if (hi !== 32'h0 || lo !== 32'h0000_FFFF) begin bad++; $display("[TB] FAIL start_beats_result: got %h_%h expected 00000000_0000ffff", hi, lo); end
    endtask

    task automatic test_reset_abort();
        int pulses;
        @(negedge clk);
        a = 32'h0000_CAFE; mthi = 1'b1; mtlo = 1'b1;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        op = OP_MULT; a = 32'h1234_5677; b = 32'h0000_0333; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        total++; if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin bad++; $display("[TB] FAIL abort_state: got busy=%b hi=%h lo=%h expected 0/0/0", busy, hi, lo); end
        pulses = 0;
        for (int c = 0; c < 45; c++) begin
            if (done || busy) pulses++;
            @(negedge clk);
        end
        total++; if (pulses != 0 || lo !== 32'h0) begin bad++; $display("[TB] FAIL abort_no_done: got %0d active cycles lo=%h expected 0/0", pulses, lo); end
    endtask

    task automatic test_back_to_back();
        int          d;
        int          bc;
        logic [31:0] x1;
        logic [31:0] y1;
        logic [31:0] x2;
        logic [31:0] y2;
        logic [63:0] e1;
        logic [63:0] e2;
        x1 = $urandom; y1 = $urandom;
        x2 = $urandom; y2 = 32'($urandom_range(1, 1000));
        e1 = model(OP_MULT, x1, y1);
        e2 = model(OP_DIV, x2, y2);
        run_op(1'b0, OP_MULT, x1, y1, d, bc);
        total++; if ({hi, lo} !== e1 || d != 35) begin bad++; $display("[TB] FAIL b2b_first: got %h_%h at %0d expected %h_%h at 35", hi, lo, d, e1[63:32], e1[31:0]); end
        run_op(1'b1, OP_DIV, x2, y2, d, bc);
        total++; if (d != 35 || bc != 34) begin bad++; $display("[TB] FAIL b2b_latency: got done=%0d busy=%0d expected 35/34", d, bc); end
        total++; if ({hi, lo} !== e2) begin bad++; $display("[TB] FAIL b2b_second: got %h_%h expected %h_%h", hi, lo, e2[63:32], e2[31:0]); end
    endtask

    initial begin
        test_reset();
        test_multiply();
        test_divide();
        test_random();
        test_moves();
        test_reset_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
